// File: rtl/lfsr_pkg.sv
// Shared types, default tap mask and the LFSR next-state function
// used by the lfsr_bank seed expander.
package lfsr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Default feedback mask: taps at bits 15, 14, 12 and 3.
    localparam logic [15:0] LFSR_DEFAULT_TAPS = 16'hD008;

    // Widest channel the helper function supports.
    localparam int LFSR_MAX_W = 64;

    // One Fibonacci step: shift left, feedback parity of tapped bits into bit 0.
    // Operates on a zero-extended value; width selects the live bits.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
        input logic [LFSR_MAX_W-1:0] state,
        input logic [LFSR_MAX_W-1:0] taps,
        input int unsigned           width
    );
        logic [LFSR_MAX_W-1:0] mask;
        logic                  fb;
        mask = (width >= LFSR_MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
        fb   = ^(state & taps & mask);
        return {state[LFSR_MAX_W-2:0], fb} & mask;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// One LFSR lane: state register, all-zero seed substitution, next-state
// logic and (when LFSR_WRAP_DETECT_EN is defined) a period-wrap detector.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int              WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS = WIDTH'(LFSR_DEFAULT_TAPS),
    parameter int              CH    = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] seed_i,
    output logic [WIDTH-1:0] state_o,
    output logic             lockup_o,
    output logic             wrap_o
);

    // An all-zero seed would lock the register; lane c substitutes c+1.
    localparam logic [WIDTH-1:0] ZERO_SUB = WIDTH'(CH + 1);

    logic [WIDTH-1:0] state_q, state_d;
    logic             lockup_q, lockup_d;
    logic [WIDTH-1:0] next_val;

    assign next_val = WIDTH'(lfsr_next(LFSR_MAX_W'(state_q), LFSR_MAX_W'(TAPS), WIDTH));

    // Load (with zero substitution) has priority over stepping.
    always_comb begin
        state_d  = state_q;
        lockup_d = lockup_q;
        if (load) begin
            if (seed_i == '0) begin
                state_d  = ZERO_SUB;
                lockup_d = 1'b1;
            end else begin
                state_d  = seed_i;
                lockup_d = 1'b0;
            end
        end else if (step) begin
            state_d = next_val;
        end
    end

    // Lane state and sticky lockup flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= '0;
            lockup_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            lockup_q <= lockup_d;
        end
    end

    assign state_o  = state_q;
    assign lockup_o = lockup_q;

`ifdef LFSR_WRAP_DETECT_EN
    logic [WIDTH-1:0] origin_q, origin_d;
    logic             wrap_q, wrap_d;

    // Remember the loaded value; flag a step that lands back on it.
    always_comb begin
        origin_d = origin_q;
        wrap_d   = 1'b0;
        if (load) begin
            origin_d = state_d;
        end else if (step) begin
            wrap_d = (next_val == origin_q);
        end
    end

    // Origin register and single-cycle wrap pulse, aligned with state_q.
    always_ff @(posedge clk) begin
        if (reset) begin
            origin_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            origin_q <= origin_d;
            wrap_q   <= wrap_d;
        end
    end

    assign wrap_o = wrap_q;
`else
    assign wrap_o = 1'b0;
`endif

endmodule

// File: rtl/lfsr_bank.sv
// lfsr_bank: CHANNELS independent Fibonacci LFSRs sharing one tap mask,
// with seed-load handshake, step enable, step counter and output valid.
// Optional macro LFSR_WRAP_DETECT_EN enables per-lane period-wrap pulses;
// without it the wrap port is tied low.
module lfsr_bank
    import lfsr_pkg::*;
#(
    parameter int               WIDTH    = 16,
    parameter int               CHANNELS = 4,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(LFSR_DEFAULT_TAPS),
    parameter int               CNT_W    = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      seed_valid,
    output logic                      seed_ready,
    input  logic [CHANNELS*WIDTH-1:0] seed,
    input  logic                      step_en,
    output logic                      out_valid,
    output logic [CHANNELS*WIDTH-1:0] out,
    output logic [CHANNELS-1:0]       lockup,
    output logic [CNT_W-1:0]          step_count,
    output logic [CHANNELS-1:0]       wrap
);

    state_t           state_q, state_d;
    logic             seed_ready_q, seed_ready_d;
    logic [CNT_W-1:0] step_count_q, step_count_d;
    logic             load;
    logic             step;

    // Reset priority in the register block makes seed_valid irrelevant
    // during the reset cycle; ready is low until the cycle after reset.
    assign load = seed_valid && seed_ready_q;
    assign step = (state_q == RUN) && step_en && !load;

    // Next-state, handshake and counter logic.
    always_comb begin
        state_d      = state_q;
        seed_ready_d = 1'b1;
        step_count_d = step_count_q;
        case (state_q)
            IDLE: if (load) state_d = RUN;
            RUN:  state_d = RUN;
            default: state_d = IDLE;
        endcase
        if (load) begin
            step_count_d = '0;
        end else if (step) begin
            step_count_d = step_count_q + CNT_W'(1);
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            seed_ready_q <= 1'b0;
            step_count_q <= '0;
        end else begin
            state_q      <= state_d;
            seed_ready_q <= seed_ready_d;
            step_count_q <= step_count_d;
        end
    end

    assign seed_ready = seed_ready_q;
    assign out_valid  = (state_q == RUN);
    assign step_count = step_count_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        lfsr_core #(
            .WIDTH (WIDTH),
            .TAPS  (TAPS),
            .CH    (c)
        ) u_core (
            .clk      (clk),
            .reset    (reset),
            .load     (load),
            .step     (step),
            .seed_i   (seed[c*WIDTH +: WIDTH]),
            .state_o  (out[c*WIDTH +: WIDTH]),
            .lockup_o (lockup[c]),
            .wrap_o   (wrap[c])
        );
    end

endmodule

// File: tb/tb_lfsr_bank.sv
// Testbench for lfsr_bank: default 16x4 bank plus a 4-bit single-lane bank
// used for the period-wrap check, both against a behavioural model.
module tb_lfsr_bank;

`ifdef LFSR_WRAP_DETECT_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    localparam logic [63:0] TAPS_L = 64'hD008;
    localparam logic [63:0] TAPS_S = 64'hC;

    logic        clk = 1'b0;
    logic        reset;
    logic        seed_valid, step_en;
    logic [63:0] seed;
    logic        seed_ready, out_valid;
    logic [63:0] out;
    logic [3:0]  lockup, wrap;
    logic [31:0] step_count;

    logic        seed_valid_s, step_en_s;
    logic [3:0]  seed_s;
    logic        seed_ready_s, out_valid_s;
    logic [3:0]  out_s;
    logic [0:0]  lockup_s, wrap_s;
    logic [7:0]  step_count_s;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lfsr_bank u_dut (
        .clk        (clk),
        .reset      (reset),
        .seed_valid (seed_valid),
        .seed_ready (seed_ready),
        .seed       (seed),
        .step_en    (step_en),
        .out_valid  (out_valid),
        .out        (out),
        .lockup     (lockup),
        .step_count (step_count),
        .wrap       (wrap)
    );

    lfsr_bank #(
        .WIDTH    (4),
        .CHANNELS (1),
        .TAPS     (4'hC),
        .CNT_W    (8)
    ) u_small (
        .clk        (clk),
        .reset      (reset),
        .seed_valid (seed_valid_s),
        .seed_ready (seed_ready_s),
        .seed       (seed_s),
        .step_en    (step_en_s),
        .out_valid  (out_valid_s),
        .out        (out_s),
        .lockup     (lockup_s),
        .step_count (step_count_s),
        .wrap       (wrap_s)
    );

    // Reference model state: large bank
    logic [15:0] m_out [4];
    logic [15:0] m_orig[4];
    logic [3:0]  m_lock, m_wrap;
    logic [31:0] m_cnt;
    bit          m_run, m_rdy;
    // Reference model state: small bank
    logic [3:0]  s_out, s_orig;
    bit          s_lock, s_wrap, s_run, s_rdy;
    logic [7:0]  s_cnt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Arithmetic form of one LFSR step: feedback is the parity of the tapped bits.
    function automatic logic [63:0] nxt(input logic [63:0] s, input logic [63:0] t, input int w);
        logic [63:0] fb;
        fb = 64'($countones(s & t) % 2);
        return ((s * 2) + fb) % (64'd1 << w);
    endfunction

    task automatic model_edge();
        bit          ld, st;
        logic [63:0] v;
        if (reset) begin
            for (int c = 0; c < 4; c++) begin m_out[c] = '0; m_orig[c] = '0; end
            m_lock = '0; m_wrap = '0; m_cnt = '0; m_run = 0; m_rdy = 0;
            s_out = '0; s_orig = '0; s_lock = 0; s_wrap = 0; s_cnt = '0; s_run = 0; s_rdy = 0;
            return;
        end
        ld = seed_valid && m_rdy;
        st = m_run && step_en && !ld;
        m_wrap = '0;
        if (ld) begin
            for (int c = 0; c < 4; c++) begin
                v = 64'(seed[c*16 +: 16]);
                if (v == 0) begin v = 64'(c + 1); m_lock[c] = 1'b1; end
                else m_lock[c] = 1'b0;
                m_out[c] = v[15:0]; m_orig[c] = v[15:0];
            end
            m_cnt = '0; m_run = 1;
        end else if (st) begin
            for (int c = 0; c < 4; c++) begin
                v = nxt(64'(m_out[c]), TAPS_L, 16);
                m_out[c] = v[15:0];
                if (WRAP_EN && m_out[c] == m_orig[c]) m_wrap[c] = 1'b1;
            end
            m_cnt = m_cnt + 1;
        end
        m_rdy = 1;

        ld = seed_valid_s && s_rdy;
        st = s_run && step_en_s && !ld;
        s_wrap = 0;
        if (ld) begin
            if (seed_s == 0) begin s_out = 4'd1; s_lock = 1; end
            else begin s_out = seed_s; s_lock = 0; end
            s_orig = s_out; s_cnt = '0; s_run = 1;
        end else if (st) begin
            v = nxt(64'(s_out), TAPS_S, 4);
            s_out = v[3:0];
            if (WRAP_EN && s_out == s_orig) s_wrap = 1;
            s_cnt = s_cnt + 1;
        end
        s_rdy = 1;
    endtask

    task automatic compare();
        logic [63:0] exp_out;
        for (int c = 0; c < 4; c++) exp_out[c*16 +: 16] = m_out[c];
        chk("seed_ready", 64'(seed_ready), 64'(m_rdy));
        chk("out_valid",  64'(out_valid),  64'(m_run));
        chk("out",        out,             exp_out);
        chk("lockup",     64'(lockup),     64'(m_lock));
        chk("step_count", 64'(step_count), 64'(m_cnt));
        chk("wrap",       64'(wrap),       64'(m_wrap));
        chk("s_seed_ready", 64'(seed_ready_s), 64'(s_rdy));
        chk("s_out_valid",  64'(out_valid_s),  64'(s_run));
        chk("s_out",        64'(out_s),        64'(s_out));
        chk("s_lockup",     64'(lockup_s),     64'(s_lock));
        chk("s_step_count", 64'(step_count_s), 64'(s_cnt));
        chk("s_wrap",       64'(wrap_s),       64'(s_wrap));
    endtask

    // One clock: model follows the edge, outputs compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    initial begin
        int wraps;
        int wrap_step;
        reset = 1; seed_valid = 0; step_en = 0; seed = '0;
        seed_valid_s = 0; step_en_s = 0; seed_s = '0;
        @(negedge clk);
        cycle();
        cycle();
        reset = 0;
        cycle();

        // IDLE ignores step_en
        step_en = 1;
        for (int i = 0; i < 5; i++) cycle();
        chk("idle_out", out, 64'h0);
        chk("idle_ready", 64'(seed_ready), 64'h1);

        // Directed load then one step
        seed = {16'h1234, 16'hD008, 16'h8000, 16'h0001};
        seed_valid = 1; step_en = 0;
        cycle();
        seed_valid = 0; step_en = 1;
        cycle();
        chk("tp_ch0", 64'(out[15:0]),  64'h0002);
        chk("tp_ch1", 64'(out[31:16]), 64'h0001);
        chk("tp_ch2", 64'(out[47:32]), 64'hA010);
        chk("tp_cnt", 64'(step_count), 64'h1);

        // Zero seed on lane 2
        step_en = 0;
        seed = {16'h1111, 16'h0000, 16'h2222, 16'h3333};
        seed_valid = 1;
        cycle();
        chk("tp_sub", 64'(out[47:32]), 64'h0003);
        chk("tp_lock", 64'(lockup), 64'h4);
        seed = {16'h1111, 16'h4444, 16'h2222, 16'h3333};
        cycle();
        chk("tp_unlock", 64'(lockup), 64'h0);

        // Ten steps, then load and step together
        seed_valid = 0; step_en = 1;
        for (int i = 0; i < 10; i++) cycle();
        seed = {4{16'h0001}}; seed_valid = 1;
        cycle();
        chk("tp_ldwin", out, {4{16'h0001}});
        chk("tp_ldcnt", 64'(step_count), 64'h0);

        // Reset while stepping at count 7
        seed_valid = 0;
        for (int i = 0; i < 7; i++) cycle();
        reset = 1;
        cycle();
        chk("tp_rst_out", out, 64'h0);
        chk("tp_rst_vld", 64'(out_valid), 64'h0);
        reset = 0; step_en = 0;
        cycle();

        // Small bank: period-15 wrap
        seed_s = 4'h1; seed_valid_s = 1;
        cycle();
        seed_valid_s = 0; step_en_s = 1;
        wraps = 0; wrap_step = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (wrap_s[0]) begin
                wraps++;
                wrap_step = i;
                chk("wrap_out", 64'(out_s), 64'h1);
            end
        end
        chk("wrap_count", 64'(wraps), WRAP_EN ? 64'd1 : 64'd0);
        chk("wrap_step",  64'(wrap_step), WRAP_EN ? 64'd15 : 64'd0);
        step_en_s = 0;

        // Randomised traffic on both banks
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 63) == 0);
            seed_valid = ($urandom_range(0, 7) == 0);
            step_en    = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < 4; c++)
                seed[c*16 +: 16] = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
            seed_valid_s = ($urandom_range(0, 15) == 0);
            step_en_s    = ($urandom_range(0, 3) != 0);
            seed_s       = ($urandom_range(0, 4) == 0) ? 4'h0 : 4'($urandom);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
